kamacore_lsu: RTL and testbench
===============================

# kamacore_lsu

Load/store unit sitting between the kamacore execute stage and the data port of the core's word-wide memory. It accepts one RISC-V load or store per request and performs the memory access. Sub-word stores run as a read-modify-write because the memory only writes full words. It returns a sign- or zero-extended load result, or a fault, through a one-cycle response strobe.

## Interface
- `MEM_ADDR_WIDTH`, default `ADDR_WIDTH`: word-address width of the memory port.
- Data width is the package constant `CPU_WIDTH` (32).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; a request transfers when `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- `req_addr`  in  CPU_WIDTH  byte address.
- `req_wdata`  in  CPU_WIDTH  store data; low byte/half used for B/H.
- `rsp_valid`  out  1  one-cycle completion strobe.
- `rsp_rdata`  out  CPU_WIDTH  load result; 0 for stores and faults.
- `rsp_fault`  out  1  qualified by `rsp_valid`.
- `mem_we`  out  1  memory write enable.
- `mem_a`  out  MEM_ADDR_WIDTH  memory word address.
- `mem_di`  out  CPU_WIDTH  memory write data.
- `mem_spo`  in  CPU_WIDTH  memory asynchronous read data for `mem_a`.

## Operation
- FSM states: IDLE, LOAD, MERGE, WRITE, RESP. Reset state is IDLE.
- **IDLE**
  - `req_ready`=1.
  - On handshake, latch `we`, `funct3`, `wdata` and word address `req_addr[MEM_ADDR_WIDTH+1:2]`. Higher address bits are ignored, so the address wraps modulo memory size.
  - Next state: fault → RESP; load → LOAD; SW → WRITE; SB/SH → MERGE.
- **Fault**: any of
  - illegal funct3 (011, 11x);
  - store with BU/HU;
  - misaligned address, when the misalignment check is compiled in (see Configuration).
  - A fault performs no memory access.
- **LOAD**
  - Drive `mem_a`.
  - Register the selected lane from `mem_spo`, little-endian: byte lane = addr[1:0], half lane = addr[1].
  - Sign-extend for B/H, zero-extend for BU/HU.
  - Next state: RESP.
- **MERGE**
  - Drive `mem_a`.
  - Register `mem_spo` with the target byte/half lane replaced by the store data.
  - Next state: WRITE.
- **WRITE**
  - `mem_we`=1, `mem_a` = latched address, `mem_di` = merged word (or full `wdata` for SW).
  - The memory commits at the closing edge.
  - Next state: RESP.
- **RESP**
  - `rsp_valid`=1, `rsp_fault` per request.
  - Next state: IDLE.
- `req_ready`=0 in every state except IDLE. There is no back-pressure on the response, so the consumer must accept it in that cycle.
- `rsp_rdata` and `rsp_fault` hold their value until the next RESP.
- Async reset mid-operation:
  - immediately returns to IDLE and drops `mem_we`;
  - a pending WRITE is abandoned;
  - no response is issued.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_fault`=0, `mem_we`=0, `mem_a`=0, `mem_di`=0.
- All outputs are registered or decoded from state only; there are no combinational paths from `req_*` to outputs.
- Latency, counted from the handshake edge (cycle 0) to `rsp_valid` high:
  - load: cycle 2;
  - SW: cycle 2;
  - SB/SH: cycle 3;
  - fault: cycle 1.
- Throughput: a new request can be accepted in the cycle after RESP.
- `mem_we` is high for exactly one cycle per store, never for loads or faults.
- During MERGE, `mem_spo` is sampled in the same cycle `mem_a` is driven (asynchronous-read memory).

## Configuration
- `KAMACORE_LSU_MISALIGN_FAULT_EN` defined:
  - H/HU with addr[0]≠0 faults;
  - W with addr[1:0]≠0 faults.
- Undefined:
  - misaligned accesses never fault;
  - the offending low address bits are forced to zero (H uses addr[1] only; W uses lane 0);
  - the access proceeds normally.

## Test plan
- Reset, then memory word 5 = 0x8899AABB; LB at byte address 0x16 → `rsp_valid` at cycle 2, `rsp_rdata`=0xFFFFFF99, fault 0; LBU at the same address → 0x00000099.
- SB of 0x12 to byte address 0x15 with word 5 = 0x8899AABB → `mem_we` high for one cycle at cycle 2; word 5 becomes 0x889912BB; `rsp_valid` at cycle 3.
- SW of 0xDEADBEEF to 0x20 → word 8 = 0xDEADBEEF; LH at 0x22 → 0xFFFFDEAD; LHU at 0x20 → 0x0000BEEF.
- LW at 0x21:
  - macro defined → `rsp_fault`=1 at cycle 1, no `mem_we`, word unchanged;
  - macro undefined → returns word 8.
- Illegal funct3=011 load and SBU-style store (we=1, funct3=100) → fault at cycle 1 with `rsp_rdata`=0; `req_ready` low from cycle 1 until RESP ends.
- SH in flight with `rst_n` asserted during MERGE → `mem_we` never rises, word unchanged, no `rsp_valid`, `req_ready`=1 immediately after reset.

Source files
------------

// File: rtl/kamacore_lsu.sv
// kamacore_lsu: load/store unit between the execute stage and a word-wide,
// asynchronous-read data memory. It performs one access per request. Sub-word
// stores are done as read-modify-write. Every request ends with a one-cycle
// response strobe.
// Optional feature: define KAMACORE_LSU_MISALIGN_FAULT_EN to make misaligned
// H/HU/W accesses fault. When it is undefined, the offending low address bits
// are dropped and the access proceeds normally.

package kamacore_pkg;
    localparam int CPU_WIDTH  = 32;
    localparam int ADDR_WIDTH = 10;
endpackage

module kamacore_lsu
    import kamacore_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [2:0]                req_funct3,
    input  logic [CPU_WIDTH-1:0]      req_addr,
    input  logic [CPU_WIDTH-1:0]      req_wdata,
    output logic                      rsp_valid,
    output logic [CPU_WIDTH-1:0]      rsp_rdata,
    output logic                      rsp_fault,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_a,
    output logic [CPU_WIDTH-1:0]      mem_di,
    input  logic [CPU_WIDTH-1:0]      mem_spo
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MERGE,
        ST_WRITE,
        ST_RESP
    } state_t;

    state_t                    state_q, state_d;
    logic                      we_q, we_d;
    logic [2:0]                funct3_q, funct3_d;
    logic [1:0]                off_q, off_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CPU_WIDTH-1:0]      data_q, data_d;
    logic [CPU_WIDTH-1:0]      rdata_q, rdata_d;
    logic                      fault_q, fault_d;

    logic                      req_fault;
    logic [7:0]                lane_b;
    logic [15:0]               lane_h;
    logic [CPU_WIDTH-1:0]      load_val;
    logic [CPU_WIDTH-1:0]      merge_val;
    logic                      unused_addr_bits;

    // The address wraps modulo the memory size, so the upper byte-address bits
    // are deliberately dropped.
    assign unused_addr_bits = ^req_addr[CPU_WIDTH-1:MEM_ADDR_WIDTH+2];

    // Decide at handshake time whether the request faults without touching memory
    always_comb begin
        req_fault = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                    (req_we && req_funct3[2]);
`ifdef KAMACORE_LSU_MISALIGN_FAULT_EN
        if ((req_funct3[1:0] == 2'b01) && req_addr[0]) begin
            req_fault = 1'b1;
        end
        if ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00)) begin
            req_fault = 1'b1;
        end
`endif
    end

    // Lane extraction for loads and lane replacement for sub-word stores (little-endian)
    always_comb begin
        lane_b    = mem_spo[{off_q, 3'b000} +: 8];
        lane_h    = mem_spo[{off_q[1], 4'b0000} +: 16];
        load_val  = mem_spo;
        merge_val = mem_spo;
        case (funct3_q)
            3'b000:  load_val = {{(CPU_WIDTH-8){lane_b[7]}}, lane_b};
            3'b100:  load_val = {{(CPU_WIDTH-8){1'b0}}, lane_b};
            3'b001:  load_val = {{(CPU_WIDTH-16){lane_h[15]}}, lane_h};
            3'b101:  load_val = {{(CPU_WIDTH-16){1'b0}}, lane_h};
            default: load_val = mem_spo;
        endcase
        if (funct3_q[1:0] == 2'b00) begin
            merge_val[{off_q, 3'b000} +: 8] = data_q[7:0];
        end else begin
            merge_val[{off_q[1], 4'b0000} +: 16] = data_q[15:0];
        end
    end

    // Next-state and next-register computation for the access sequencer
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    off_d    = req_addr[1:0];
                    addr_d   = req_addr[MEM_ADDR_WIDTH+1:2];
                    data_d   = req_wdata;
                    if (req_fault) begin
                        // Response fields only change on entry to RESP, so they hold in between.
                        rdata_d = '0;
                        fault_d = 1'b1;
                        state_d = ST_RESP;
                    end else if (!req_we) begin
                        state_d = ST_LOAD;
                    end else if (req_funct3 == 3'b010) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_MERGE;
                    end
                end
            end
            ST_LOAD: begin
                rdata_d = load_val;
                fault_d = 1'b0;
                state_d = ST_RESP;
            end
            ST_MERGE: begin
                data_d  = merge_val;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                rdata_d = '0;
                fault_d = 1'b0;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; an async reset abandons any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            off_q    <= 2'b00;
            addr_q   <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign mem_we    = (state_q == ST_WRITE);
    assign mem_a     = addr_q;
    assign mem_di    = data_q;
    assign rsp_rdata = rdata_q;
    assign rsp_fault = fault_q;

endmodule

// File: tb/tb_kamacore_lsu.sv
// Testbench for kamacore_lsu. It has directed steps followed by random loads and
// stores. Results are compared against a word-array reference model.
`timescale 1ns/1ps

module tb_kamacore_lsu;

    localparam int AW    = 10;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'b000;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_fault;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [31:0]   mem_di;
    logic [31:0]   mem_spo;

    logic          tb_we = 1'b0;
    logic [AW-1:0] tb_wa = '0;
    logic [31:0]   tb_wd = '0;

    logic [31:0]   mem [0:WORDS-1];
    logic [31:0]   ref_mem [0:WORDS-1];

    int total = 0;
    int bad   = 0;

    kamacore_lsu #(.MEM_ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_di     (mem_di),
        .mem_spo    (mem_spo)
    );

    always #5 clk = ~clk;

    // Asynchronous-read memory with a second write port for the bench's preloading.
    assign mem_spo = mem[mem_a];
    always @(posedge clk) begin
        if (mem_we) mem[mem_a] <= mem_di;
        else if (tb_we) mem[tb_wa] <= tb_wd;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int wa, input logic [31:0] v);
        @(negedge clk);
        tb_we = 1'b1; tb_wa = wa[AW-1:0]; tb_wd = v;
        @(negedge clk);
        tb_we = 1'b0;
        ref_mem[wa] = v;
    endtask

    // Issue one request, then check the latency, the store strobe, the response and the memory.
    task automatic run_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        int wa, off, hoff, lat_exp, cyc, we_cnt, we_cyc;
        logic [31:0] w, b, h, exp_rd, new_w;
        logic exp_f, done, ready_bad;
        wa  = int'((addr >> 2) & (WORDS - 1));
        off = int'(addr & 3);
        hoff = off - (off % 2);
        w   = ref_mem[wa];
        new_w = w;
        exp_rd = 32'h0;
        exp_f = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
                (we && (f3 == 3'b100 || f3 == 3'b101));
`ifdef KAMACORE_LSU_MISALIGN_FAULT_EN
        if ((f3 == 3'b001 || f3 == 3'b101) && (off % 2) != 0) exp_f = 1'b1;
        if (f3 == 3'b010 && off != 0) exp_f = 1'b1;
`endif
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (8 * hoff)) & 32'hFFFF;
        if (exp_f) begin
            lat_exp = 1;
        end else if (!we) begin
            lat_exp = 2;
            case (f3)
                3'b000:  exp_rd = (b >= 128) ? b + 32'hFFFFFF00 : b;
                3'b100:  exp_rd = b;
                3'b001:  exp_rd = (h >= 32768) ? h + 32'hFFFF0000 : h;
                3'b101:  exp_rd = h;
                default: exp_rd = w;
            endcase
        end else if (f3 == 3'b010) begin
            lat_exp = 2;
            new_w = wd;
        end else if (f3 == 3'b000) begin
            lat_exp = 3;
            new_w = (w & ~(32'hFF << (8 * off))) | ((wd & 32'hFF) << (8 * off));
        end else begin
            lat_exp = 3;
            new_w = (w & ~(32'hFFFF << (8 * hoff))) | ((wd & 32'hFFFF) << (8 * hoff));
        end

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        chk("ready_before", {31'b0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1; done = 1'b0; ready_bad = 1'b0; we_cnt = 0; we_cyc = 0;
        while (!done && cyc <= 8) begin
            if (req_ready !== 1'b0) ready_bad = 1'b1;
            if (mem_we === 1'b1) begin we_cnt++; we_cyc = cyc; end
            if (rsp_valid === 1'b1) done = 1'b1;
            else begin @(posedge clk); #1; cyc++; end
        end
        chk("latency", done ? cyc : 999, lat_exp);
        chk("ready_low", {31'b0, ready_bad}, 32'h0);
        chk("rdata", rsp_rdata, exp_rd);
        chk("fault", {31'b0, rsp_fault}, {31'b0, exp_f});
        chk("we_count", we_cnt, (we && !exp_f) ? 1 : 0);
        if (we && !exp_f) chk("we_cycle", we_cyc, lat_exp - 1);
        chk("mem_word", mem[wa], new_w);
        ref_mem[wa] = new_w;
        @(posedge clk); #1;
        chk("rsp_pulse", {31'b0, rsp_valid}, 32'h0);
        chk("ready_after", {31'b0, req_ready}, 32'h1);
        chk("rdata_hold", rsp_rdata, exp_rd);
        $display("txn we=%0d f3=%03b addr=%h wdata=%h -> rdata=%h fault=%0d lat=%0d",
                 we, f3, addr, wd, rsp_rdata, rsp_fault, cyc);
    endtask

    initial begin
        logic [2:0] legal_f3 [0:4];
        logic       r_we;
        logic [2:0] r_f3;
        logic [31:0] r_addr;
        int          spurious;
        legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
        legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_fault", {31'b0, rsp_fault}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_a", {22'b0, mem_a}, 32'h0);
        chk("rst_mem_di", mem_di, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) set_word(i, $urandom);

        // Directed steps
        set_word(5, 32'h8899AABB);
        run_req(1'b0, 3'b000, 32'h16, 32'h0);          // LB  -> FFFFFF99
        run_req(1'b0, 3'b100, 32'h16, 32'h0);          // LBU -> 00000099
        run_req(1'b1, 3'b000, 32'h15, 32'h12);         // SB  -> word 5 = 889912BB
        run_req(1'b1, 3'b010, 32'h20, 32'hDEADBEEF);   // SW
        run_req(1'b0, 3'b001, 32'h22, 32'h0);          // LH  -> FFFFDEAD
        run_req(1'b0, 3'b101, 32'h20, 32'h0);          // LHU -> 0000BEEF
        run_req(1'b0, 3'b010, 32'h21, 32'h0);          // misaligned LW
        run_req(1'b0, 3'b011, 32'h20, 32'h0);          // illegal funct3
        run_req(1'b1, 3'b100, 32'h20, 32'hFFFFFFFF);   // store with BU code
        run_req(1'b1, 3'b001, 32'h1F, 32'hA5A5);       // misaligned SH
        run_req(1'b0, 3'b010, 32'hFFFF_F014, 32'h0);   // wrapped address -> word 5

        // Async reset during MERGE of an SH abandons the write
        set_word(6, 32'h13579BDF);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h1A; req_wdata = 32'h5555;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("merge_no_we", {31'b0, mem_we}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("arst_ready", {31'b0, req_ready}, 32'h1);
        chk("arst_we", {31'b0, mem_we}, 32'h0);
        chk("arst_valid", {31'b0, rsp_valid}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || mem_we !== 1'b0 || req_ready !== 1'b1) spurious++;
        end
        chk("arst_quiet", spurious, 0);
        chk("arst_word", mem[6], ref_mem[6]);
        $display("txn reset-during-merge word6=%h", mem[6]);

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            r_we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) r_f3 = 3'($urandom_range(0, 7));
            else r_f3 = legal_f3[$urandom_range(0, 4)];
            r_addr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) |
                     32'($urandom_range(0, 3));
            run_req(r_we, r_f3, r_addr, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
